// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// The host side uses master; the loader uses slave.
interface imem_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wd, core_rst_n, busy, done, error
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wd, core_rst_n, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed, XOR-checked program image into instruction memory; holds the core in reset until success.
// Write pulse lands one cycle after a word's 4th byte; byte_ready stays high through it, so bytes may stream back-to-back.
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] idx;
    logic [1:0]  lane;
    logic [23:0] acc;
    logic [7:0]  csum;

    logic        ready_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic        core_rst_n_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic        xfer;
    logic [15:0] n_hdr;

    assign xfer  = bus.byte_valid && ready_q;
    assign n_hdr = {bus.byte_data, cnt[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            lane         <= '0;
            acc          <= '0;
            csum         <= '0;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= BASE_ADDR;
            wd_q         <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state        <= HDR_LO;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        csum         <= '0;
                        idx          <= '0;
                        lane         <= '0;
                        busy_q       <= 1'b1;
                        ready_q      <= 1'b1;
                        core_rst_n_q <= 1'b0;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        cnt[7:0] <= bus.byte_data;
                        csum     <= csum ^ bus.byte_data;
                        state    <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        cnt  <= n_hdr;
                        csum <= csum ^ bus.byte_data;
                        if ({1'b0, n_hdr} > DEPTH_W) begin
                            state   <= ERR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end else if (n_hdr == 16'd0) begin
                            state <= CHK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum ^ bus.byte_data;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: acc[7:0]   <= bus.byte_data;
                            2'd1: acc[15:8]  <= bus.byte_data;
                            2'd2: acc[23:16] <= bus.byte_data;
                            default: begin
                                // Word complete: the write pulse is the registered copy, visible next cycle.
                                we_q   <= 1'b1;
                                addr_q <= BASE_ADDR + {14'd0, idx, 2'b00};
                                wd_q   <= {bus.byte_data, acc};
                                idx    <= idx + 16'd1;
                                if (idx + 16'd1 == cnt) begin
                                    state <= CHK;
                                end
                            end
                        endcase
                    end
                end
                CHK: begin
                    if (xfer) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                        if (bus.byte_data == csum) begin
                            state        <= DONE;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            state   <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wd     = wd_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule
